// File: rtl/ebus_xfer_ctl.sv
// ebus_xfer_ctl: EBOX-side EBUS transfer sequencer and N-way data mux.
//   Runs one CONO/CONI/DATAO/DATAI/PI cycle per accepted start through the
//   DEMAND -> HOLD -> RELEASE handshake, with a per-state timeout. It ORs
//   NDRV device drivers (plus its own write data) onto busData and flags
//   multi-driver conflicts.
// Optional feature: define EBUS_PARITY_EN to generate odd parity on busParity.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   start, func, cs,       request pulse and its function / controller select /
//   wrData                 write data, latched when start is accepted
//   drvData, drvDriving    per-device data words and driving flags
//   busXfer                device transfer-done
//   busData, busParity     muxed EBUS data (combinational) and its parity
//   busCs, busFunc,        EBUS controller select, function and demand
//   busDemand
//   rdData                 data captured in HOLD for read functions
//   busy, done             transaction in progress / one-cycle completion
//   timeout, conflict      sticky abort and multi-driver flags
module ebus_xfer_ctl #(
  parameter int unsigned NDRV    = 8,
  parameter int unsigned DATAW   = 36,
  parameter int unsigned CSW     = 7,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            func,
  input  logic [CSW-1:0]        cs,
  input  logic [DATAW-1:0]      wrData,
  input  logic [NDRV*DATAW-1:0] drvData,
  input  logic [NDRV-1:0]       drvDriving,
  input  logic                  busXfer,
  output logic [DATAW-1:0]      busData,
  output logic [CSW-1:0]        busCs,
  output logic [2:0]            busFunc,
  output logic                  busDemand,
  output logic                  busParity,
  output logic [DATAW-1:0]      rdData,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic                  conflict
);

  localparam int unsigned CNTW = 8;
  localparam int unsigned POPW = $clog2(NDRV + 2);

  localparam logic [2:0] FUNC_CONO  = 3'b000;
  localparam logic [2:0] FUNC_DATAO = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEMAND,
    S_HOLD,
    S_RELEASE
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        func_q, func_d;
  logic [CSW-1:0]    cs_q, cs_d;
  logic [DATAW-1:0]  wr_q, wr_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [DATAW-1:0]  rd_q, rd_d;
  logic              timeout_q, timeout_d;
  logic              conflict_q, conflict_d;
  logic              done_q, done_d;
  logic              demand_q, demand_d;
  logic              busy_q, busy_d;
  logic [CSW-1:0]    bus_cs_q, bus_cs_d;
  logic [2:0]        bus_func_q, bus_func_d;

  logic              is_write_c;
  logic              self_drive_c;
  logic [DATAW-1:0]  bus_data_c;
  logic [POPW-1:0]   pop_c;
  logic [CNTW-1:0]   cnt_inc_c;

  assign is_write_c   = (func_q == FUNC_CONO) || (func_q == FUNC_DATAO);
  // The controller drives its write data exactly while demand is asserted.
  assign self_drive_c = demand_q && is_write_c;
  assign cnt_inc_c    = cnt_q + CNTW'(1);

  // Wired-OR data mux and driver population count.
  always_comb begin
    bus_data_c = '0;
    pop_c      = '0;
    for (int i = 0; i < int'(NDRV); i++) begin
      if (drvDriving[i]) begin
        bus_data_c = bus_data_c | drvData[i*DATAW +: DATAW];
      end
      pop_c = pop_c + POPW'(drvDriving[i]);
    end
    if (self_drive_c) begin
      bus_data_c = bus_data_c | wr_q;
    end
    pop_c = pop_c + POPW'(self_drive_c);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    func_d     = func_q;
    cs_d       = cs_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    timeout_d  = timeout_q;
    conflict_d = conflict_q || ((state_q != S_IDLE) && (pop_c > POPW'(1)));
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          func_d     = func;
          cs_d       = cs;
          wr_d       = wrData;
          timeout_d  = 1'b0;
          conflict_d = 1'b0;
          cnt_d      = '0;
          state_d    = S_DEMAND;
        end
      end
      S_DEMAND: begin
        if (busXfer) begin
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == CNTW'(TIMEOUT)) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = S_RELEASE;
          end
        end
      end
      S_HOLD: begin
        if (!is_write_c) begin
          rd_d = bus_data_c;
        end
        cnt_d   = '0;
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!busXfer) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == CNTW'(TIMEOUT)) begin
            timeout_d = 1'b1;
            done_d    = 1'b1;
            cnt_d     = '0;
            state_d   = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    demand_d   = (state_d == S_DEMAND) || (state_d == S_HOLD);
    busy_d     = (state_d != S_IDLE);
    bus_cs_d   = demand_d ? cs_d : '0;
    bus_func_d = demand_d ? func_d : '0;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      func_q     <= '0;
      cs_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      timeout_q  <= 1'b0;
      conflict_q <= 1'b0;
      done_q     <= 1'b0;
      demand_q   <= 1'b0;
      busy_q     <= 1'b0;
      bus_cs_q   <= '0;
      bus_func_q <= '0;
    end else begin
      state_q    <= state_d;
      func_q     <= func_d;
      cs_q       <= cs_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      timeout_q  <= timeout_d;
      conflict_q <= conflict_d;
      done_q     <= done_d;
      demand_q   <= demand_d;
      busy_q     <= busy_d;
      bus_cs_q   <= bus_cs_d;
      bus_func_q <= bus_func_d;
    end
  end

  assign busData   = bus_data_c;
  assign busCs     = bus_cs_q;
  assign busFunc   = bus_func_q;
  assign busDemand = demand_q;
  assign rdData    = rd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign conflict  = conflict_q;

`ifdef EBUS_PARITY_EN
  // Odd parity: XOR of busData and busParity is 1.
  assign busParity = ~^bus_data_c;
`else
  assign busParity = 1'b0;
`endif

endmodule

// File: tb/tb_ebus_xfer_ctl.sv
// Testbench for ebus_xfer_ctl: directed plan cases plus randomized
// transactions checked cycle by cycle against a transaction-level model.
module tb_ebus_xfer_ctl;

  localparam int unsigned NDRV    = 8;
  localparam int unsigned DATAW   = 36;
  localparam int unsigned CSW     = 7;
  localparam int unsigned TIMEOUT = 63;

  localparam logic [2:0] F_CONO  = 3'b000;
  localparam logic [2:0] F_CONI  = 3'b001;
  localparam logic [2:0] F_DATAI = 3'b011;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [2:0]            func;
  logic [CSW-1:0]        cs;
  logic [DATAW-1:0]      wrData;
  logic [NDRV*DATAW-1:0] drvData;
  logic [NDRV-1:0]       drvDriving;
  logic                  busXfer;
  logic [DATAW-1:0]      busData;
  logic [CSW-1:0]        busCs;
  logic [2:0]            busFunc;
  logic                  busDemand;
  logic                  busParity;
  logic [DATAW-1:0]      rdData;
  logic                  busy;
  logic                  done;
  logic                  timeout;
  logic                  conflict;

  int checks = 0;
  int errors = 0;
  logic [DATAW-1:0] rd_model = '0;

  always #5 clk = ~clk;

  ebus_xfer_ctl #(
    .NDRV(NDRV), .DATAW(DATAW), .CSW(CSW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .func(func), .cs(cs),
    .wrData(wrData), .drvData(drvData), .drvDriving(drvDriving),
    .busXfer(busXfer), .busData(busData), .busCs(busCs), .busFunc(busFunc),
    .busDemand(busDemand), .busParity(busParity), .rdData(rdData),
    .busy(busy), .done(done), .timeout(timeout), .conflict(conflict)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_parity(input logic [DATAW-1:0] d);
`ifdef EBUS_PARITY_EN
    return ~^d;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DATAW-1:0] or_drivers(input logic [NDRV-1:0] mask,
                                                  input logic [NDRV*DATAW-1:0] dd);
    logic [DATAW-1:0] r = '0;
    for (int i = 0; i < int'(NDRV); i++)
      if (mask[i]) r = r | dd[i*DATAW +: DATAW];
    return r;
  endfunction

  task automatic idle_inputs();
    start = 1'b0; func = '0; cs = '0; wrData = '0;
    drvData = '0; drvDriving = '0; busXfer = 1'b0;
  endtask

  // One transaction. k = DEMAND cycles the device waits before raising busXfer
  // (>= TIMEOUT means never); m = RELEASE cycles it keeps busXfer high.
  task automatic run_xfer(input string tag, input logic [2:0] f, input logic [CSW-1:0] c_s,
                          input logic [DATAW-1:0] wr, input logic [NDRV-1:0] mask,
                          input logic [NDRV*DATAW-1:0] dd, input int k, input int m);
    bit is_wr, exp_to, exp_cf, in_dem, in_hold, in_rel;
    int dem, hold, rel, rel_start, done_c;
    logic [DATAW-1:0] dev_or, exp_bus, rd_before;
    is_wr     = (f == 3'b000) || (f == 3'b010);
    hold      = (k < int'(TIMEOUT)) ? 1 : 0;
    dem       = (hold == 1) ? k + 1 : int'(TIMEOUT);
    rel       = (m < int'(TIMEOUT)) ? m + 1 : int'(TIMEOUT);
    rel_start = 1 + dem + hold;
    done_c    = rel_start + rel;
    exp_to    = (hold == 0) || (m >= int'(TIMEOUT));
    exp_cf    = ($countones(mask) + (is_wr ? 1 : 0)) > 1;
    dev_or    = or_drivers(mask, dd);
    rd_before = rd_model;
    if (!is_wr && hold == 1) rd_model = dev_or;

    for (int cyc = 0; cyc <= done_c + 1; cyc++) begin
      in_dem  = (cyc >= 1) && (cyc <= dem);
      in_hold = (hold == 1) && (cyc == dem + 1);
      in_rel  = (cyc >= rel_start) && (cyc < rel_start + rel);
      // Start again at cycle 2 with junk request fields: must be ignored.
      start  = (cyc == 0) || (cyc == 2);
      func   = (cyc == 0) ? f   : 3'($urandom);
      cs     = (cyc == 0) ? c_s : CSW'($urandom);
      wrData = (cyc == 0) ? wr  : DATAW'({$urandom, $urandom});
      busXfer = in_dem  ? ((cyc - 1) >= k) :
                in_hold ? 1'b1 :
                in_rel  ? ((cyc - rel_start) < m) : 1'b0;
      drvData    = dd;
      drvDriving = (cyc <= done_c) ? mask : '0;
      @(negedge clk);
      exp_bus = ((cyc <= done_c) ? dev_or : '0) | ((is_wr && (in_dem || in_hold)) ? wr : '0);
      chk({tag, ".busData"}, 64'(busData), 64'(exp_bus));
      chk({tag, ".busParity"}, 64'(busParity), 64'(exp_parity(exp_bus)));
      chk({tag, ".busDemand"}, 64'(busDemand), 64'(in_dem || in_hold));
      chk({tag, ".busCs"}, 64'(busCs), (in_dem || in_hold) ? 64'(c_s) : 64'(0));
      chk({tag, ".busFunc"}, 64'(busFunc), (in_dem || in_hold) ? 64'(f) : 64'(0));
      chk({tag, ".busy"}, 64'(busy), 64'((cyc >= 1) && (cyc < done_c)));
      chk({tag, ".done"}, 64'(done), 64'(cyc == done_c));
      if (cyc == 1) begin
        chk({tag, ".timeout_clr"}, 64'(timeout), 64'(0));
        chk({tag, ".conflict_clr"}, 64'(conflict), 64'(0));
        chk({tag, ".rdData_hold"}, 64'(rdData), 64'(rd_before));
      end
      if (cyc == done_c) begin
        chk({tag, ".timeout"}, 64'(timeout), 64'(exp_to));
        chk({tag, ".conflict"}, 64'(conflict), 64'(exp_cf));
        chk({tag, ".rdData"}, 64'(rdData), 64'(rd_model));
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busData"}, 64'(busData), 64'(0));
    chk({tag, ".busCs"}, 64'(busCs), 64'(0));
    chk({tag, ".busFunc"}, 64'(busFunc), 64'(0));
    chk({tag, ".busDemand"}, 64'(busDemand), 64'(0));
    chk({tag, ".busParity"}, 64'(busParity), 64'(exp_parity('0)));
    chk({tag, ".rdData"}, 64'(rdData), 64'(0));
    chk({tag, ".busy"}, 64'(busy), 64'(0));
    chk({tag, ".done"}, 64'(done), 64'(0));
    chk({tag, ".timeout"}, 64'(timeout), 64'(0));
    chk({tag, ".conflict"}, 64'(conflict), 64'(0));
  endtask

  initial begin
    logic [NDRV*DATAW-1:0] dd;
    logic [NDRV-1:0]       mask;
    int                    k, m;

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // DATAI, device 3 answers after 2 DEMAND cycles, holds xfer 1 RELEASE cycle.
    dd = '0;
    dd[3*DATAW +: DATAW] = 36'o123456701234;
    run_xfer("datai", F_DATAI, 7'o12, '0, 8'b0000_1000, dd, 2, 1);

    // CONO, self-driven only, minimum latency.
    run_xfer("cono", F_CONO, 7'o3, 36'o777000000001, '0, '0, 0, 0);

    // DATAI with no busXfer ever: DEMAND timeout.
    run_xfer("dem_to", F_DATAI, 7'o5, '0, '0, '0, 1000, 0);

    // Good read clears timeout.
    dd = '0;
    dd[0 +: DATAW] = 36'o555;
    run_xfer("after_to", F_DATAI, 7'o6, '0, 8'b0000_0001, dd, 0, 0);

    // RELEASE timeout: busXfer never drops.
    run_xfer("rel_to", F_DATAI, 7'o7, '0, '0, '0, 1, 1000);

    // CONI with drivers 1 and 5: conflict, rdData captures the OR.
    dd = '0;
    dd[1*DATAW +: DATAW] = 36'o1;
    dd[5*DATAW +: DATAW] = 36'o2;
    run_xfer("coni_cf", F_CONI, 7'o11, '0, 8'b0010_0010, dd, 1, 0);

    // Reset in HOLD together with start: reset wins, no done follows.
    start = 1'b1; func = F_DATAI; cs = 7'o12;
    @(posedge clk); #1;
    start = 1'b0; busXfer = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b1; busXfer = 1'b1;
    drvDriving = 8'b0000_0100;
    drvData = '0;
    drvData[2*DATAW +: DATAW] = 36'o707070707070;
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    rd_model = '0;
    @(negedge clk);
    chk_all_zero("rst_hold");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_hold.no_done", 64'(done), 64'(0));
      chk("rst_hold.idle", 64'(busy), 64'(0));
    end
    @(posedge clk); #1;

    // Randomized transactions.
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < int'(NDRV); i++)
        dd[i*DATAW +: DATAW] = DATAW'({$urandom, $urandom});
      case ($urandom_range(0, 3))
        0:       mask = '0;
        1:       mask = NDRV'(1) << $urandom_range(0, NDRV - 1);
        default: mask = NDRV'($urandom);
      endcase
      k = ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(0, 4));
      m = ($urandom_range(0, 9) == 0) ? 100 : int'($urandom_range(0, 3));
      run_xfer("rand", 3'($urandom), CSW'($urandom), DATAW'({$urandom, $urandom}),
               mask, dd, k, m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ebus_xfer_ctl.md
Name: ebus_xfer_ctl

Overview:
EBOX-side EBUS transfer sequencer and N-way data mux. This is the parametrised successor to the fixed EBUS driver/interface definitions.
- Runs one CONO/CONI/DATAO/DATAI/PI cycle per request through demand/xfer handshake with timeout.
- ORs NDRV device drivers onto the bus and flags multi-driver conflicts.
- Sits between the EBOX microcode I/O request logic and the iEBUS signals.

Parameters:
NDRV, 8, number of device drivers muxed onto EBUS data (1..32)
DATAW, 36, EBUS data width
CSW, 7, controller-select width
TIMEOUT, 63, max cycles waited in any handshake state before abort (1..255)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  request pulse; accepted only when busy=0
func  in  3  tEBUSfunction code, latched on accepted start
cs  in  CSW  controller select, latched on accepted start
wrData  in  DATAW  EBOX write data for CONO/DATAO, latched on accepted start
drvData  in  NDRV*DATAW  per-device data, driver i at bits [i*DATAW +: DATAW]
drvDriving  in  NDRV  per-device driving flags
busXfer  in  1  device transfer-done
busData  out  DATAW  muxed EBUS data
busCs  out  CSW  EBUS controller select
busFunc  out  3  EBUS function
busDemand  out  1  EBUS demand
busParity  out  1  EBUS parity (see Optional Feature)
rdData  out  DATAW  captured read data
busy  out  1  transaction in progress
done  out  1  one-cycle completion pulse
timeout  out  1  sticky abort flag, cleared on next accepted start
conflict  out  1  sticky multi-driver flag, cleared on next accepted start

Behaviour:
- Reset:
  - All outputs are 0 and the state is IDLE, including reset asserted mid-transaction; no done pulse results.
  - Reset wins over a simultaneous start.
- Write funcs: CONO (000) and DATAO (010). The controller is itself a bus driver with wrData from DEMAND through HOLD.
- Read funcs: CONI, DATAI, PIserved, PIaddrIn.
- States:
  - IDLE:
    - busy=0.
    - On start, latch func/cs/wrData, clear timeout/conflict, zero the counter, and go to DEMAND.
    - busy=1 from the next cycle.
  - DEMAND:
    - busDemand=1; busCs/busFunc = latched values.
    - If busXfer=1, go to HOLD.
    - Otherwise the counter increments. If it equals TIMEOUT, set timeout and go to RELEASE.
  - HOLD:
    - Exactly one cycle, busDemand=1.
    - For read funcs, rdData <= busData this cycle.
    - Then zero the counter and go to RELEASE.
  - RELEASE:
    - busDemand=0 and busCs/busFunc=0.
    - Wait for busXfer=0, then go to IDLE with done=1 in the IDLE-entry cycle and busy=0 in that same cycle.
    - If busXfer stays high for TIMEOUT cycles, set timeout and go to IDLE with done=1.
- Latency: minimum start-to-done is 4 cycles (start, DEMAND, HOLD, RELEASE, done on IDLE entry), given busXfer high in DEMAND's first cycle and low in RELEASE's first cycle.
- Mux:
  - busData is combinational: the bitwise OR of all drvData words with drvDriving set, plus wrData when the controller drives.
  - With no drivers active, busData=0.
- Conflict:
  - Set when popcount(drvDriving, self-drive) > 1 in any non-IDLE cycle.
  - A conflict does not abort the transaction; rdData captures the OR.
- start while busy is ignored; no queueing.
- rdData holds its value until the next read capture. It is unchanged by timeout or write transactions.

Optional Feature:
Macro EBUS_PARITY_EN.
- Defined: busParity = odd parity over busData, combinational, so the XOR of busData and busParity is 1.
- Not defined: busParity tied 0 and no parity logic is synthesised.

Test Plan:
- DATAI, cs=7'o12, device 3 drives 36'o123456701234 and raises busXfer 2 cycles after demand, drops it 1 cycle after demand falls -> rdData=36'o123456701234, done once, timeout=0, conflict=0.
- CONO, wrData=36'o777000000001, no device drives, busXfer held high in the first DEMAND cycle and low in RELEASE -> busData=wrData during DEMAND/HOLD, done exactly 4 cycles after start, rdData unchanged.
- DATAI with busXfer never asserted, TIMEOUT=63 -> timeout=1 after 63 DEMAND cycles, busDemand drops, done pulses. A following good transaction clears timeout.
- CONI with drivers 1 and 5 both driving (36'o1, 36'o2) -> conflict=1, rdData=36'o3, transaction still completes.
- reset asserted while in HOLD with start high in the same cycle -> next cycle all outputs 0, state IDLE, no done. start ignored while busy -> no second transaction.
- EBUS_PARITY_EN defined, busData=36'o0 -> busParity=1. busData=36'o1 -> busParity=0. With the macro undefined -> busParity=0 always.
